// File: rtl/skinny_2shares_host_ctrl.sv
// Byte-stream host controller for the 2-share SKINNY-128-384 core.
// SKINNY_CTRL_UNMASK_EN: XOR the two cipher shares on-chip and send 16 bytes.
module skinny_2shares_host_ctrl #(
  parameter logic [7:0] FRAME_HDR  = 8'hA5,
  parameter int         LOAD_BYTES = 248
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic [255:0]  input_o,
  output logic [255:0]  key_o,
  output logic [127:0]  tweak1_o,
  output logic [127:0]  tweak2_o,
  output logic [1215:0] random_o,
  output logic          start_o,
  input  logic [255:0]  cipher_i,
  input  logic          done_i,
  output logic          busy_o
);

  localparam int LW = LOAD_BYTES * 8;
`ifdef SKINNY_CTRL_UNMASK_EN
  localparam int TXW = 128;
`else
  localparam int TXW = 256;
`endif
  localparam logic [5:0] TXN  = 6'(TXW / 8);
  localparam logic [7:0] LAST = 8'(LOAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_ARM, S_BUSY, S_SEND
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       ld_cnt_q, ld_cnt_d;
  logic [5:0]       tx_cnt_q, tx_cnt_d;
  logic [LW-1:0]    ld_q, ld_d;
  logic [TXW-1:0]   tx_q, tx_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             start_q, start_d;
  logic             tx_vld_q, tx_vld_d;
  logic             busy_q, busy_d;
  logic             rx_acc;
  logic [TXW-1:0]   cap;

`ifdef SKINNY_CTRL_UNMASK_EN
  assign cap = cipher_i[255:128] ^ cipher_i[127:0];
`else
  assign cap = cipher_i;
`endif

  assign rx_acc = rx_valid_i && rx_rdy_q;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    tx_cnt_d = tx_cnt_q;
    ld_d     = ld_q;
    tx_d     = tx_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_acc && rx_data_i == FRAME_HDR) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (rx_acc) begin
          ld_d     = {ld_q[LW-9:0], rx_data_i};
          ld_cnt_d = ld_cnt_q + 8'd1;
          if (ld_cnt_q == LAST) state_d = S_START;
        end
      end
      S_START: state_d = S_ARM;
      // done_i still reflects the previous idle state here
      S_ARM:   state_d = S_BUSY;
      S_BUSY: begin
        if (done_i) begin
          tx_d     = cap;
          tx_cnt_d = TXN;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready_i) begin
          tx_d     = tx_q << 8;
          tx_cnt_d = tx_cnt_q - 6'd1;
          if (tx_cnt_q == 6'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_rdy_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    start_d  = (state_d == S_START);
    tx_vld_d = (state_d == S_SEND);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      tx_cnt_q <= '0;
      ld_q     <= '0;
      tx_q     <= '0;
      rx_rdy_q <= 1'b1;
      start_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      ld_q     <= ld_d;
      tx_q     <= tx_d;
      rx_rdy_q <= rx_rdy_d;
      start_q  <= start_d;
      tx_vld_q <= tx_vld_d;
      busy_q   <= busy_d;
    end
  end

  assign rx_ready_o = rx_rdy_q;
  assign start_o    = start_q;
  assign tx_valid_o = tx_vld_q;
  assign busy_o     = busy_q;
  assign tx_data_o  = tx_q[TXW-1 -: 8];
  assign {input_o, key_o, tweak1_o, tweak2_o, random_o} = ld_q;

endmodule

// File: tb/tb_skinny_2shares_host_ctrl.sv
// Randomized bench for skinny_2shares_host_ctrl with a frame/byte-queue model.
// Follows SKINNY_CTRL_UNMASK_EN for the expected TX stream.
module tb_skinny_2shares_host_ctrl;

  localparam int NB = 248;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    rx_data_i = '0;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic [255:0]  input_o;
  logic [255:0]  key_o;
  logic [127:0]  tweak1_o;
  logic [127:0]  tweak2_o;
  logic [1215:0] random_o;
  logic          start_o;
  logic [255:0]  cipher_i = '0;
  logic          done_i = 1'b1;
  logic          busy_o;

  skinny_2shares_host_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .input_o    (input_o),
    .key_o      (key_o),
    .tweak1_o   (tweak1_o),
    .tweak2_o   (tweak2_o),
    .random_o   (random_o),
    .start_o    (start_o),
    .cipher_i   (cipher_i),
    .done_i     (done_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int lat = 200;
  logic [255:0] cur_cipher = '0;
  logic [7:0]   pl [NB];
  logic [7:0]   exp_tx [$];

  task automatic chk(input string tag, input logic [1215:0] got,
                     input logic [1215:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (start_o) start_cnt++;

  // core model: done drops on entry to BUSY, rises lat cycles later
  always begin
    @(negedge clk);
    if (start_o) begin
      cipher_i = {cur_cipher[127:0] ^ 128'h5, cur_cipher[255:128]};
      @(posedge clk);
      @(posedge clk);
      #1 done_i = 1'b0;
      repeat (lat) @(posedge clk);
      #1 done_i = 1'b1;
      cipher_i = cur_cipher;
      @(negedge clk);
      chk("tx_early", 1216'(tx_valid_o), 1216'(1'b0));
      @(posedge clk);
      @(negedge clk);
      chk("tx_lat", 1216'(tx_valid_o), 1216'(1'b1));
    end
  end

  task automatic prep_cipher(input logic [255:0] c);
    logic [127:0] x;
    cur_cipher = c;
    exp_tx.delete();
`ifdef SKINNY_CTRL_UNMASK_EN
    x = c[255:128] ^ c[127:0];
    for (int i = 0; i < 16; i++) exp_tx.push_back(x[127-8*i -: 8]);
`else
    x = '0;
    for (int i = 0; i < 32; i++) exp_tx.push_back(c[255-8*i -: 8]);
`endif
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NB; k++) pl[k] = 8'($urandom_range(0, 255));
    prep_cipher({$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()});
    lat = $urandom_range(3, 60);
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) chk("rx_timeout", 1216'(rx_ready_o), 1216'(1'b1));
    @(posedge clk);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic chk_ops();
    logic [NB*8-1:0] v;
    for (int k = 0; k < NB; k++) v[NB*8-1-8*k -: 8] = pl[k];
    chk("input_o",  1216'(input_o),  1216'(v[1983:1728]));
    chk("key_o",    1216'(key_o),    1216'(v[1727:1472]));
    chk("tweak1_o", 1216'(tweak1_o), 1216'(v[1471:1344]));
    chk("tweak2_o", 1216'(tweak2_o), 1216'(v[1343:1216]));
    chk("random_o", random_o,        v[1215:0]);
  endtask

  task automatic send_frame(input bit hdr);
    if (hdr) begin
      send_byte(8'hA5);
      chk("hdr_busy", 1216'(busy_o), 1216'(1'b1));
    end
    for (int k = 0; k < NB; k++) send_byte(pl[k]);
    chk("start_lat", 1216'(start_o), 1216'(1'b1));
    chk_ops();
  endtask

  // mode 0: always ready, 1: toggle, 2: random
  task automatic recv(input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < exp_tx.size() && cyc < 5000) begin
      case (mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid_o) begin
        chk("tx_byte", 1216'(tx_data_o), 1216'(exp_tx[idx]));
        if (tx_ready_i) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready_i = 1'b0;
    if (idx < exp_tx.size()) chk("tx_timeout", 1216'(idx), 1216'(exp_tx.size()));
    chk("tx_end_valid", 1216'(tx_valid_o), 1216'(1'b0));
    chk("tx_end_busy",  1216'(busy_o),     1216'(1'b0));
  endtask

  initial begin
    #1 rst_i = 1'b0;
    #2;
    chk("rst_busy",   1216'(busy_o),     1216'(1'b0));
    chk("rst_rdy",    1216'(rx_ready_o), 1216'(1'b1));
    chk("rst_start",  1216'(start_o),    1216'(1'b0));
    chk("rst_txv",    1216'(tx_valid_o), 1216'(1'b0));
    chk("rst_txd",    1216'(tx_data_o),  1216'(8'h00));
    chk("rst_input",  1216'(input_o),    1216'(0));
    chk("rst_random", random_o,          1216'(0));
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // counting payload with the fixed cipher pattern
    for (int k = 0; k < NB; k++) pl[k] = 8'(k);
    prep_cipher({{16{8'h11}}, {16{8'h22}}});
    lat = 200;
    send_frame(1'b1);
    chk("in_msb",  1216'(input_o[255:248]), 1216'(8'h00));
    chk("rnd_lsb", 1216'(random_o[7:0]),    1216'(8'hF7));
    chk("key_msb", 1216'(key_o[255:248]),   1216'(8'h20));
    recv(0);
    chk("start_cnt1", 1216'(start_cnt), 1216'(1));

    // garbage before header, toggled sink, header held during BUSY
    send_byte(8'h00);
    chk("garb0", 1216'(busy_o), 1216'(1'b0));
    send_byte(8'hFF);
    chk("garb1", 1216'(busy_o), 1216'(1'b0));
    send_byte(8'h5A);
    chk("garb2", 1216'(busy_o), 1216'(1'b0));
    rand_frame();
    send_frame(1'b1);
    fork
      recv(1);
      begin
        rx_data_i  = 8'hA5;
        rx_valid_i = 1'b1;
        @(negedge clk);
        chk("rx_ready_busy", 1216'(rx_ready_o), 1216'(1'b0));
        send_byte(8'hA5);
        chk("held_hdr", 1216'(busy_o), 1216'(1'b1));
      end
    join
    chk("start_cnt2", 1216'(start_cnt), 1216'(2));

    rand_frame();
    send_frame(1'b0);
    recv(2);
    chk("start_cnt3", 1216'(start_cnt), 1216'(3));

    // reset after 100 payload bytes
    rand_frame();
    send_byte(8'hA5);
    for (int k = 0; k < 100; k++) send_byte(pl[k]);
    rst_i = 1'b0;
    #1;
    chk("mid_busy",   1216'(busy_o),     1216'(1'b0));
    chk("mid_rdy",    1216'(rx_ready_o), 1216'(1'b1));
    chk("mid_random", random_o,          1216'(0));
    chk("mid_tweak2", 1216'(tweak2_o),   1216'(0));
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (300) @(negedge clk);
    chk("mid_nostart", 1216'(start_cnt),  1216'(3));
    chk("mid_notx",    1216'(tx_valid_o), 1216'(1'b0));
    rand_frame();
    send_frame(1'b1);
    recv(2);
    chk("start_cnt4", 1216'(start_cnt), 1216'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
